spi_fifo_drain: RTL and testbench

Downstream consumer of the pixel FIFO: pops 9-bit words `{dc, byte}` from the BRAM-backed FIFO and serializes them onto an SPI-style LCD link (mode 0, MSB first), so the renderer never stalls on display bandwidth. It handles the FIFO's registered-read timing, keeps chip-select low across back-to-back bytes, and releases the bus when the FIFO drains.

---
 rtl/spi_fifo_drain.sv | 76 +++++++
 tb/tb_spi_fifo_drain.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_drain.sv
// spi_fifo_drain: pops {dc,byte} words from the pixel FIFO and shifts them out as SPI mode 0, MSB first
module spi_fifo_drain #(
  parameter int CLKDIV   = 2,
  parameter int DATABITS = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DATABITS-1:0] fifo_data,
  input  logic                fifo_empty,
  output logic                fifo_read_en,
  output logic                spi_sck,
  output logic                spi_mosi,
  output logic                spi_dc,
  output logic                spi_cs_n,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, END} state_t;
  state_t state, nxt;
  logic [7:0] div, sreg;
  logic [2:0] bitcnt;
  logic go, tick, last;
  assign go   = enable && !fifo_empty;
  assign tick = div == 8'(CLKDIV - 1);
  assign last = tick && spi_sck && bitcnt == 3'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (go ? LOAD : IDLE) :
          state == LOAD  ? SHIFT :
          state == SHIFT ? (last ? END : SHIFT) :
                           (go ? LOAD : IDLE);
  always_comb fifo_read_en = state == LOAD;
  // cs_n/busy are released from IDLE, so back-to-back bytes keep the bus selected through END
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_dc   <= 1'b0;
      spi_cs_n <= 1'b1;
      busy     <= 1'b0;
      div      <= '0;
      sreg     <= '0;
      bitcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          spi_cs_n <= 1'b1;
          busy     <= 1'b0;
        end
        LOAD: begin
          sreg     <= fifo_data[7:0];
          spi_mosi <= fifo_data[7];
          spi_dc   <= fifo_data[DATABITS-1];
          bitcnt   <= 3'd7;
          div      <= '0;
          spi_sck  <= 1'b0;
          spi_cs_n <= 1'b0;
          busy     <= 1'b1;
        end
        SHIFT: begin
          div <= tick ? '0 : div + 8'd1;
          if (tick) begin
            spi_sck <= !spi_sck;
            if (spi_sck && bitcnt != 3'd0) begin
              sreg     <= {sreg[6:0], 1'b0};
              spi_mosi <= sreg[6];
              bitcnt   <= bitcnt - 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_spi_fifo_drain.sv
// tb_spi_fifo_drain: two instances (CLKDIV 2 and 1) fed by FIFO models, MOSI bytes checked against a scoreboard
module tb_spi_fifo_drain;
  typedef struct {
    logic [8:0] word;
    logic       exp_dc;
    logic [7:0] exp_byte;
    int         exp_run;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
  always #5 clk = ~clk;
  wire [1:0] rd, sck, mosi, dcs, csn, bsy;
  logic [8:0] mem0 [16], mem1 [16];
  int wp [2], rp [2];
  wire [8:0] fd0 = mem0[rp[0][3:0]];
  wire [8:0] fd1 = mem1[rp[1][3:0]];
  wire emp0 = wp[0] == rp[0];
  wire emp1 = wp[1] == rp[1];
  spi_fifo_drain #(.CLKDIV(2)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_data(fd0), .fifo_empty(emp0),
    .fifo_read_en(rd[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_dc(dcs[0]),
    .spi_cs_n(csn[0]), .busy(bsy[0]));
  spi_fifo_drain #(.CLKDIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_data(fd1), .fifo_empty(emp1),
    .fifo_read_en(rd[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_dc(dcs[1]),
    .spi_cs_n(csn[1]), .busy(bsy[1]));
  int checks, passes;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a == e) passes++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask
  always @(posedge clk)
    for (int d = 0; d < 2; d++) if (rd[d] && wp[d] != rp[d]) rp[d] <= rp[d] + 1;
  logic [8:0] expq [$];
  int pop_t [$];
  int cyc, nbit [2], npop [2], run [2], last_run [2], nrise [2], last_rise [2], sck_gap [2];
  logic [7:0] acc [2];
  logic psck [2], pcs [2];
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        nbit[d] = 0; psck[d] = 1'b0; pcs[d] = 1'b1; run[d] = 0;
      end else begin
        if (rd[d]) begin
          npop[d]++;
          pop_t.push_back(cyc);
          chk("pop_nonempty", int'(wp[d] != rp[d]), 1);
        end
        if (sck[d] && !psck[d]) begin
          if (nbit[d] != 0) sck_gap[d] = cyc - last_rise[d];
          last_rise[d] = cyc;
          nrise[d]++;
          acc[d] = {acc[d][6:0], mosi[d]};
          nbit[d]++;
          if (nbit[d] == 8) begin
            nbit[d] = 0;
            chk("exp_available", int'(expq.size() > 0), 1);
            if (expq.size() > 0) chk("byte", int'({dcs[d], acc[d]}), int'(expq.pop_front()));
          end
        end
        if (!csn[d]) run[d]++;
        else begin
          if (!pcs[d]) last_run[d] = run[d];
          run[d] = 0;
        end
        psck[d] = sck[d]; pcs[d] = csn[d];
      end
    end
  end
  task automatic push(input int d, input logic [8:0] w);
    if (d == 0) mem0[wp[0][3:0]] = w;
    else mem1[wp[1][3:0]] = w;
    wp[d]++;
  endtask
  task automatic wait_done(input int d);
    int n = 0;
    while (!(expq.size() == 0 && wp[d] == rp[d] && csn[d] && !bsy[d]) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("done_timeout", int'(n < 3000), 1);
    @(negedge clk);
  endtask
  task automatic wait_cs(input int d);
    int n = 0;
    while (!(csn[d] && !bsy[d]) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("cs_timeout", int'(n < 3000), 1);
    @(negedge clk);
  endtask
  task automatic wait_pop(input int d);
    int n = 0;
    while (!rd[d] && n < 200) begin
      @(negedge clk); n++;
    end
    chk("pop_timeout", int'(rd[d]), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  vec_t t2 [4], t6 [4];
  int p;
  initial begin
    t2[0] = '{9'h1A5, 1'b1, 8'hA5, 34};
    t2[1] = '{9'h03C, 1'b0, 8'h3C, 34};
    t2[2] = '{9'h100, 1'b1, 8'h00, 34};
    t2[3] = '{9'h0FF, 1'b0, 8'hFF, 34};
    t6[0] = '{9'h1F0, 1'b1, 8'hF0, 72};
    t6[1] = '{9'h00F, 1'b0, 8'h0F, 72};
    t6[2] = '{9'h181, 1'b1, 8'h81, 72};
    t6[3] = '{9'h07E, 1'b0, 8'h7E, 72};
    repeat (3) @(negedge clk);
    chk("rst_read_en", int'(rd[0]), 0);
    chk("rst_sck", int'(sck[0]), 0);
    chk("rst_mosi", int'(mosi[0]), 0);
    chk("rst_dc", int'(dcs[0]), 0);
    chk("rst_cs_n", int'(csn[0]), 1);
    chk("rst_busy", int'(bsy[0]), 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_pops", npop[0] + npop[1], 0);
    chk("idle_cs_n", int'(csn[0]), 1);
    chk("idle_sck", int'(sck[0]), 0);
    for (int i = 0; i < 4; i++) begin
      p = npop[0];
      expq.push_back({t2[i].exp_dc, t2[i].exp_byte});
      push(0, t2[i].word);
      @(negedge clk);
      chk("load_latency", int'(rd[0]), 1);
      wait_done(0);
      chk("single_pops", npop[0] - p, 1);
      chk("single_cs_low", last_run[0], t2[i].exp_run);
      chk("single_dc_hold", int'(dcs[0]), int'(t2[i].exp_dc));
    end
    p = npop[0];
    pop_t.delete();
    expq.push_back(9'h0FF); expq.push_back(9'h000); expq.push_back(9'h13C);
    push(0, 9'h0FF); push(0, 9'h000); push(0, 9'h13C);
    wait_done(0);
    chk("burst_pops", npop[0] - p, 3);
    chk("burst_cs_low", last_run[0], 102);
    chk("burst_gap1", pop_t[1] - pop_t[0], 34);
    chk("burst_gap2", pop_t[2] - pop_t[1], 34);
    p = npop[0];
    expq.push_back(9'h155); expq.push_back(9'h0AA);
    push(0, 9'h155); push(0, 9'h0AA);
    wait_pop(0);
    repeat (15) @(negedge clk);
    enable = 1'b0;
    wait_cs(0);
    chk("en_drop_pops", npop[0] - p, 1);
    chk("en_drop_cs_low", last_run[0], 34);
    repeat (40) @(negedge clk);
    chk("en_hold_pops", npop[0] - p, 1);
    chk("en_hold_cs_n", int'(csn[0]), 1);
    chk("en_hold_pending", expq.size(), 1);
    enable = 1'b1;
    wait_done(0);
    chk("en_resume_pops", npop[0] - p, 2);
    push(0, 9'h1C3);
    wait_pop(0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read_en", int'(rd[0]), 0);
    chk("mid_rst_sck", int'(sck[0]), 0);
    chk("mid_rst_mosi", int'(mosi[0]), 0);
    chk("mid_rst_dc", int'(dcs[0]), 0);
    chk("mid_rst_cs_n", int'(csn[0]), 1);
    chk("mid_rst_busy", int'(bsy[0]), 0);
    expq.push_back(9'h096);
    push(0, 9'h096);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_pop(0);
    wait_done(0);
    pop_t.delete();
    p = npop[1];
    for (int i = 0; i < 4; i++) begin
      expq.push_back({t6[i].exp_dc, t6[i].exp_byte});
      push(1, t6[i].word);
    end
    wait_done(1);
    chk("div1_pops", npop[1] - p, 4);
    for (int i = 1; i < 4; i++) chk("div1_byte_period", pop_t[i] - pop_t[i-1], 18);
    chk("div1_cs_low", last_run[1], t6[3].exp_run);
    chk("div1_sck_rises", nrise[1], 32);
    chk("div1_sck_period", sck_gap[1], 2);
    chk("scoreboard_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
